mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-classification helpers. The decode stage uses the same
// encodings, so they must only ever change here.
package mdu_pkg;

  // 3-bit op encodings driven onto the MDU op port by decode
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles before committing HI/LO
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Multiplies use the multiply latency, divides the divide latency
  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers. The arithmetic is
// evaluated behaviourally when an op is accepted, parked in a result
// register, and committed to HI/LO after a fixed latency so the pipeline
// sees the same timing as an iterative unit.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_res_hi, r_res_lo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic             w_accept;
  logic             w_commit;

  logic signed [WIDTH-1:0] w_sa, w_sb;
  logic [2*WIDTH-1:0]      w_prod_s, w_prod_u;

  assign w_accept = start && (r_state == ST_IDLE);
  assign w_commit = (r_state == ST_BUSY) && (r_cnt == '0);

  assign w_sa = SrcA;
  assign w_sb = SrcB;
  // Sign- or zero-extend to the full product width; the low 2*WIDTH bits of
  // the product are then exact for both signednesses.
  assign w_prod_s = {{WIDTH{SrcA[WIDTH-1]}}, SrcA} * {{WIDTH{SrcB[WIDTH-1]}}, SrcB};
  assign w_prod_u = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};

  assign busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Result of the op currently on the inputs, including the divide corner cases
  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (op)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV: begin
        if (SrcB == '0) begin
          w_res_lo = '1;
          w_res_hi = SrcA;
        end else if ((SrcA == MIN_VAL) && (SrcB == '1)) begin
          w_res_lo = MIN_VAL;
          w_res_hi = '0;
        end else begin
          w_res_lo = w_sa / w_sb;
          w_res_hi = w_sa % w_sb;
        end
      end
      OP_DIVU: begin
        if (SrcB == '0) begin
          w_res_lo = '1;
          w_res_hi = SrcA;
        end else begin
          w_res_lo = SrcA / SrcB;
          w_res_hi = SrcA % SrcB;
        end
      end
      default: begin
        w_res_hi = '0;
        w_res_lo = '0;
      end
    endcase
  end

  // Next state and latency counter for the IDLE/BUSY sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && is_long_op(op)) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = is_mult_op(op) ? MULT_LOAD : DIV_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sequencer state register; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // HI/LO and the parked result: capture on acceptance, commit at end of BUSY
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (w_accept) begin
      case (op)
        OP_MTHI: r_hi <= SrcA;
        OP_MTLO: r_lo <= SrcA;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          r_res_hi <= w_res_hi;
          r_res_lo <= w_res_lo;
        end
        OP_NOP: begin
        end
        default: begin
        end
      endcase
    end else if (w_commit) begin
      r_hi <= r_res_hi;
      r_lo <= r_res_lo;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

endmodule
